// File: rtl/rv_imm_pkg.sv
// Shared immediate-format codes and RV32I/Zicsr opcode constants for the immediate stage.
package rv_imm_pkg;

    localparam int unsigned FMT_W = 3;
    localparam int unsigned OPC_W = 7;

    localparam logic [FMT_W-1:0] IMM_I   = 3'd0;
    localparam logic [FMT_W-1:0] IMM_S   = 3'd1;
    localparam logic [FMT_W-1:0] IMM_B   = 3'd2;
    localparam logic [FMT_W-1:0] IMM_J   = 3'd3;
    localparam logic [FMT_W-1:0] IMM_U   = 3'd4;
    localparam logic [FMT_W-1:0] IMM_Z   = 3'd5;
    localparam logic [FMT_W-1:0] IMM_ILL = 3'd6;

    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    // Codes 110/111 carry no immediate layout.
    function automatic logic fmt_is_legal(input logic [FMT_W-1:0] fmt);
        return fmt <= IMM_Z;
    endfunction

endpackage

// File: rtl/imm_extend_stage_if.sv
// Upstream/downstream handshake bundle of the immediate-generation stage.
interface imm_extend_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      in_immsrc;
    logic            in_auto;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_immext;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, in_immsrc, in_auto, out_ready,
        input  in_ready, out_valid, out_immext, out_target, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_immsrc, in_auto, out_ready,
        output in_ready, out_valid, out_immext, out_target, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_format_decode.sv
// Combinational opcode -> immediate format lookup; no_imm_c marks R-type (zero immediate, legal).
module imm_format_decode
    import rv_imm_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             funct3_msb_i,
    output logic [FMT_W-1:0] fmt_c,
    output logic             no_imm_c
);

    always_comb begin
        fmt_c    = IMM_ILL;
        no_imm_c = 1'b0;
        case (opcode_i)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt_c = IMM_I;
            OPC_STORE:                      fmt_c = IMM_S;
            OPC_BRANCH:                     fmt_c = IMM_B;
            OPC_JAL:                        fmt_c = IMM_J;
            OPC_LUI, OPC_AUIPC:             fmt_c = IMM_U;
            // CSR immediate forms (funct3[2]=1) take the zero-extended uimm field.
            OPC_SYSTEM:                     fmt_c = funct3_msb_i ? IMM_Z : IMM_I;
            OPC_OP: begin
                fmt_c    = IMM_I;
                no_imm_c = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate extension + PC-relative target, behind a valid/ready
// handshake with an output register and one skid entry.
module imm_extend_stage
    import rv_imm_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          AUTO_DECODE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    imm_extend_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] immext;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    logic [31:0]      instr;
    logic             sgn;
    logic [FMT_W-1:0] auto_fmt;
    logic             auto_none;
    logic             sel_auto;
    logic [FMT_W-1:0] fmt;
    logic             no_imm;
    logic [XLEN-1:0]  imm;
    entry_t           new_entry;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   in_fire;
    logic   out_free;

    assign instr = bus.in_instr;
    assign sgn   = instr[31];

    generate
        if (AUTO_DECODE) begin : g_dec
            imm_format_decode u_dec (
                .opcode_i     (instr[6:0]),
                .funct3_msb_i (instr[14]),
                .fmt_c        (auto_fmt),
                .no_imm_c     (auto_none)
            );
        end else begin : g_nodec
            assign auto_fmt  = IMM_ILL;
            assign auto_none = 1'b0;
        end
    endgenerate

    assign sel_auto = AUTO_DECODE && bus.in_auto;

    // Format selection and sign/zero extension of the incoming instruction.
    always_comb begin
        fmt    = sel_auto ? auto_fmt : bus.in_immsrc;
        no_imm = sel_auto && auto_none;
        imm    = '0;
        case (fmt)
            IMM_I: imm = {{(XLEN-11){sgn}}, instr[30:20]};
            IMM_S: imm = {{(XLEN-11){sgn}}, instr[30:25], instr[11:7]};
            IMM_B: imm = {{(XLEN-12){sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm = {{(XLEN-20){sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U: imm = {{(XLEN-31){sgn}}, instr[30:12], 12'b0};
            IMM_Z: imm = {{(XLEN-5){1'b0}}, instr[19:15]};
            default: imm = '0;
        endcase
        if (no_imm) begin
            imm = '0;
        end
        new_entry.immext  = imm;
        new_entry.target  = bus.in_pc + imm;
        new_entry.pc      = bus.in_pc;
        new_entry.illegal = !no_imm && !fmt_is_legal(fmt);
    end

    assign in_fire  = bus.in_valid && in_ready_q && !flush;
    assign out_free = !out_valid_q || bus.out_ready;

    // Skid empties into the output register before any new input is taken.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_immext  = out_q.immext;
    assign bus.out_target  = out_q.target;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_illegal = out_q.illegal;

endmodule
